key_schedule_ctrl: RTL
======================

// Module: key_schedule_ctrl
// PURPOSE
//  Sequential AES key-schedule engine and round-key server for the cipher/decipher cores.
//  Expands Key into 4*(Nr+1) words, one word per clock, using 4 shared S-box lookups.
//  It replaces the all-combinational expansion on the timing-critical path.
//  Stores the schedule and returns any 128-bit round key by round index, one cycle after request.
// PARAMETERS
//  Nk  4   key length in 32-bit words (4/6/8 = AES-128/192/256)
//  Nr  10  number of rounds; must equal Nk+6
// PORTS
//  clk       in   1          rising-edge clock
//  rst_n     in   1          asynchronous active-low reset
//  start     in   1          pulse: begin expansion of Key
//  Key       in   32*Nk      cipher key; bits [32*Nk-1 -: 32] = w[0] (big-endian words)
//  busy      out  1          expansion in progress
//  ready     out  1          full schedule valid
//  rk_req    in   1          round-key read request
//  rk_round  in   4          requested round index, 0..Nr
//  rk_out    out  128        round key: [127:96]=w[4r], [31:0]=w[4r+3]
//  rk_valid  out  1          1-cycle pulse: rk_out valid
//  rk_err    out  1          1-cycle pulse: request rejected
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; busy, ready, rk_valid and rk_err = 0; rk_out = 0.
//   Word store, index counter and Rcon are all cleared.
//  FSM states: IDLE, EXPAND, DONE.
//   IDLE/DONE + start: capture Key into w[0..Nk-1] and set index i=Nk.
//    Set Rcon=8'h01, busy=1 and ready=0. Go to EXPAND.
//   EXPAND: each cycle write w[i] = w[i-Nk] ^ temp, where temp is derived from w[i-1]:
//    i%Nk==0 -> SubWord(RotWord(w[i-1])) ^ {Rcon,24'h0}. After use, Rcon = xtime(Rcon)
//     (01,02,..,80,1b,36).
//    Nk>6 && i%Nk==4 -> SubWord(w[i-1]).
//    All other i -> w[i-1].
//    RotWord({a,b,c,d}) = {b,c,d,a}. SubWord applies the FIPS-197 S-box to each byte.
//   Last write is i = 4*(Nr+1)-1. On that same edge go to DONE: busy=0, ready=1.
//  Latency: ready is high L = 4*(Nr+1)-Nk cycles after the start edge (40/46/52).
//  start while in EXPAND: ignored; expansion continues unaffected.
//  start in DONE: re-expansion; ready falls on the start edge. Key is sampled only on the start edge.
//  Read port (registered, 1-cycle latency):
//   rk_req with ready=1 and rk_round<=Nr -> next edge: rk_out = w[4r..4r+3] and rk_valid=1.
//   rk_req with ready=0 or rk_round>Nr -> next edge: rk_err=1, rk_valid=0, rk_out holds.
//   No rk_req -> rk_valid=0, rk_err=0, rk_out holds its last value.
//   Back-to-back requests are allowed every cycle.
//  rk_req and start on the same DONE edge: the read returns the OLD schedule.
//   All updates are nonblocking on one edge. ready falls on that edge, so the next request errors.
//  Reset mid-EXPAND: schedule discarded, IDLE; a new start is required.
//  Width rules: XOR on 32-bit words only. i counter is 6 bits (max 59). Rcon is 8 bits with GF(2^8) xtime.
// TESTING
//  T1 AES-128, start, Key=2b7e1516_28aed2a6_abf71588_09cf4f3c -> ready after 40 cycles.
//   rk_round=1 gives a0fafe17_88542cb1_23a33939_2a6c7605.
//   rk_round=10 gives d014f9a8_c9ee2589_e13f0cc8_b6630ca6.
//  T2 Nk=6,Nr=12, Key=8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b -> ready after 46.
//   w[6]=fe0c91f7 and w[51]=01002202.
//  T3 Nk=8,Nr=14, Key=603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4
//   -> ready after 52. w[8]=9ba35411 and w[59]=706c631e.
//  T4 rk_req at cycle 5 of EXPAND -> rk_err pulse, rk_valid=0.
//   rk_round=11 with Nr=10 in DONE -> rk_err pulse.
//  T5 start mid-EXPAND with a different Key -> ignored; T1 values are still produced at cycle 40.
//   Then start+rk_req(round 0) in DONE -> rk_out=2b7e1516_..._09cf4f3c (old), ready=0.
//  T6 rst_n low at EXPAND cycle 20 -> all outputs 0 immediately (async).
//   Restart with the T1 key reproduces the T1 results after 40 cycles.

Source files
------------

// File: rtl/key_schedule_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : key_schedule_ctrl_if
// Description : Control / round-key bus for key_schedule_ctrl. It groups the
//               expansion request (start, Key), the status flags (busy, ready)
//               and the round-key read port (rk_req, rk_round, rk_out,
//               rk_valid, rk_err).
// Ports       : master - drives start, Key, rk_req, rk_round;
//                        observes busy, ready, rk_out, rk_valid, rk_err
//               slave  - the key-schedule engine (the opposite directions)
// Parameters  : Nk - key length in 32-bit words (4/6/8)
// Revision    : 1.0 - initial release
// ============================================================================
interface key_schedule_ctrl_if #(
  parameter int Nk = 4
) ();

  logic               start;
  logic [32*Nk-1:0]   Key;
  logic               busy;
  logic               ready;
  logic               rk_req;
  logic [3:0]         rk_round;
  logic [127:0]       rk_out;
  logic               rk_valid;
  logic               rk_err;

  modport master (
    output start, Key, rk_req, rk_round,
    input  busy, ready, rk_out, rk_valid, rk_err
  );

  modport slave (
    input  start, Key, rk_req, rk_round,
    output busy, ready, rk_out, rk_valid, rk_err
  );

endinterface
`default_nettype wire

// File: rtl/key_schedule_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : key_schedule_ctrl
// Description : Sequential AES key-schedule engine and round-key server.
//               Expands the cipher key into 4*(Nr+1) 32-bit words, one word
//               per clock, sharing four S-box lookups. The expanded schedule
//               is held in a word store and any 128-bit round key can be read
//               by round index with a one-cycle registered latency.
// Ports       : clk    - rising-edge clock
//               rst_n  - asynchronous active-low reset
//               bus    - slave side of key_schedule_ctrl_if:
//                          start    in  pulse, begin expansion of Key
//                          Key      in  cipher key, top word is w[0]
//                          busy     out expansion in progress
//                          ready    out full schedule valid
//                          rk_req   in  round-key read request
//                          rk_round in  requested round index 0..Nr
//                          rk_out   out round key, [127:96] = w[4r]
//                          rk_valid out 1-cycle pulse, rk_out updated
//                          rk_err   out 1-cycle pulse, request rejected
// Parameters  : Nk - key words (4/6/8); Nr - rounds, must equal Nk+6
// Revision    : 1.0 - initial release
// ============================================================================
module key_schedule_ctrl #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  key_schedule_ctrl_if.slave bus
);

  localparam int         c_NWORDS   = 4 * (Nr + 1);
  localparam logic [5:0] c_LAST_IDX = 6'(c_NWORDS - 1);
  localparam logic [5:0] c_NK       = 6'(Nk);
  localparam logic [2:0] c_KPOS_MAX = 3'(Nk - 1);
  localparam logic [3:0] c_NR       = 4'(Nr);

  // FIPS-197 S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] c_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x sits at bit offset 8*(255-x); for an 8-bit x, 255-x == ~x.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return c_SBOX[{~x, 3'b000} +: 8];
  endfunction

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic         w_load;
  logic         w_step;
  logic         w_last;

  logic [31:0]  r_w [c_NWORDS];
  logic [5:0]   r_idx;
  // Position of r_idx within the current Nk-word block (r_idx % Nk),
  // tracked incrementally so no divider is needed for Nk = 6.
  logic [2:0]   r_kpos;
  logic [7:0]   r_rcon;

  logic [31:0]  w_prev;
  logic [31:0]  w_back;
  logic [31:0]  w_sub_in;
  logic [31:0]  w_sub;
  logic [31:0]  w_temp;
  logic [7:0]   w_rcon_nxt;

  logic         w_busy;
  logic         w_ready;
  logic [5:0]   w_rd_base;
  logic [127:0] r_rk_out;
  logic         r_rk_valid;
  logic         r_rk_err;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_last = (r_idx == c_LAST_IDX);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = S_EXPAND;
        end
      end
      S_EXPAND: begin
        // start is deliberately not looked at here: a running expansion
        // always completes with the key captured on its own start edge.
        w_step = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_busy  = (r_state == S_EXPAND);
  assign w_ready = (r_state == S_DONE);

  // --------------------------------------------------------------------------
  // Expansion datapath: w[i] = w[i-Nk] ^ temp(w[i-1])
  // --------------------------------------------------------------------------
  assign w_prev   = r_w[r_idx - 6'd1];
  assign w_back   = r_w[r_idx - c_NK];

  // The four S-box lookups are shared between the RotWord case (block start)
  // and the plain SubWord case (AES-256 mid-block word).
  assign w_sub_in = (r_kpos == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
  assign w_sub    = {sbox(w_sub_in[31:24]), sbox(w_sub_in[23:16]),
                     sbox(w_sub_in[15:8]),  sbox(w_sub_in[7:0])};

  always_comb begin
    w_temp = w_prev;
    if (r_kpos == 3'd0) begin
      w_temp = w_sub ^ {r_rcon, 24'h000000};
    end else if ((Nk > 6) && (r_kpos == 3'd4)) begin
      w_temp = w_sub;
    end
  end

  // GF(2^8) multiply-by-x: 01,02,04,...,80,1b,36
  assign w_rcon_nxt = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < c_NWORDS; k++) begin
        r_w[k] <= '0;
      end
      r_idx  <= '0;
      r_kpos <= '0;
      r_rcon <= '0;
    end else if (w_load) begin
      for (int k = 0; k < Nk; k++) begin
        r_w[k] <= bus.Key[32*(Nk-1-k) +: 32];
      end
      r_idx  <= c_NK;
      r_kpos <= 3'd0;
      r_rcon <= 8'h01;
    end else if (w_step) begin
      r_w[r_idx] <= w_back ^ w_temp;
      if (!w_last) begin
        r_idx <= r_idx + 6'd1;
      end
      r_kpos <= (r_kpos == c_KPOS_MAX) ? 3'd0 : r_kpos + 3'd1;
      if (r_kpos == 3'd0) begin
        r_rcon <= w_rcon_nxt;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Round-key read port. A request coinciding with a start edge reads the
  // store before the new key lands, so it returns the previous schedule.
  // --------------------------------------------------------------------------
  assign w_rd_base = {bus.rk_round, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rk_out   <= '0;
      r_rk_valid <= 1'b0;
      r_rk_err   <= 1'b0;
    end else begin
      r_rk_valid <= 1'b0;
      r_rk_err   <= 1'b0;
      if (bus.rk_req) begin
        if (w_ready && (bus.rk_round <= c_NR)) begin
          r_rk_out   <= {r_w[w_rd_base],         r_w[w_rd_base + 6'd1],
                         r_w[w_rd_base + 6'd2],  r_w[w_rd_base + 6'd3]};
          r_rk_valid <= 1'b1;
        end else begin
          r_rk_err   <= 1'b1;
        end
      end
    end
  end

  assign bus.busy     = w_busy;
  assign bus.ready    = w_ready;
  assign bus.rk_out   = r_rk_out;
  assign bus.rk_valid = r_rk_valid;
  assign bus.rk_err   = r_rk_err;

endmodule
`default_nettype wire
